// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-ported memory
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // one extra bit so depths up to 2**ADDR_W compare correctly
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic                cap_we;
  logic                cap_id;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic                last_grant;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err_q;
  logic                grant_any;
  logic                grant_id;
  logic                in_range;

  assign in_range = ({1'b0, cap_addr} < DEPTH_EXT);

  // round-robin pick: on contention the port not served last wins
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end
  end

  // next-state and per-state handshake/memory strobes
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mem_we     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        // ready is masked while reset is held since IDLE is forced then
        if (grant_any && rst_n) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        mem_we    = cap_we & in_range;
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~cap_id;
        rsp1_valid = cap_id;
        if (cap_id ? rsp1_ready : rsp0_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // capture the granted request and register the access result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we     <= 1'b0;
      cap_id     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      last_grant <= 1'b1;
      rsp_data   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state == IDLE && grant_any) begin
        cap_we     <= grant_id ? req1_we    : req0_we;
        cap_addr   <= grant_id ? req1_addr  : req0_addr;
        cap_wdata  <= grant_id ? req1_wdata : req0_wdata;
        cap_id     <= grant_id;
        last_grant <= grant_id;
      end
      if (state == ACCESS) begin
        rsp_data  <= (cap_we || !in_range) ? '0 : mem_rdata;
        rsp_err_q <= ~in_range;
      end
    end
  end

  assign mem_addr   = cap_addr;
  assign mem_wdata  = cap_wdata;
  assign busy       = (state != IDLE);
  assign rsp0_rdata = rsp_data;
  assign rsp1_rdata = rsp_data;
  assign rsp0_err   = rsp_err_q;
  assign rsp1_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp0_valid, rsp0_ready, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int          n_cmp;
  int          n_err;
  logic        model_last;
  logic [31:0] ref_mem [0:1023];
  logic [31:0] tb_mem  [0:1023];
  logic        mem_load;
  logic [31:0] salt;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory device: combinational read, write on rising edge
  assign mem_rdata = (mem_addr < 32'd1024) ? tb_mem[mem_addr[9:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= (i * 32'h9E37_79B9) ^ salt;
    end else if (mem_we && mem_addr < 32'd1024) begin
      tb_mem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  // One transaction, entered with clk low and the DUT idle.
  task automatic run_txn(input logic v0, input logic v1,
                         input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                         input int stall, input string tag);
    logic        g, twe, exp_err, exp_we, rv, ov, re;
    logic [31:0] ta, td, exp_data, rd;
    g        = (v0 && v1) ? ~model_last : v1;
    twe      = g ? we1 : we0;
    ta       = g ? a1 : a0;
    td       = g ? d1 : d0;
    exp_err  = (ta >= 32'd1024);
    exp_we   = twe && !exp_err;
    exp_data = (twe || exp_err) ? 32'd0 : ref_mem[ta[9:0]];
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    n_cmp++;
    if (req0_ready !== ~g || req1_ready !== g || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s grant: ready0=%b ready1=%b busy=%b, expected ready0=%b ready1=%b busy=0",
               tag, req0_ready, req1_ready, busy, ~g, g);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++;
    if (mem_we !== exp_we || mem_addr !== ta || mem_wdata !== td || busy !== 1'b1 ||
        rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s access: we=%b addr=%h wdata=%h busy=%b, expected we=%b addr=%h wdata=%h busy=1",
               tag, mem_we, mem_addr, mem_wdata, busy, exp_we, ta, td);
    end
    @(posedge clk); #1;
    for (int i = 0; i <= stall; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      if (i == stall) begin
        if (g) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      end
      #1;
      rv = g ? rsp1_valid : rsp0_valid;
      ov = g ? rsp0_valid : rsp1_valid;
      rd = g ? rsp1_rdata : rsp0_rdata;
      re = g ? rsp1_err   : rsp0_err;
      n_cmp++;
      if (rv !== 1'b1 || ov !== 1'b0 || rd !== exp_data || re !== exp_err || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL %s resp[%0d]: valid=%b other=%b rdata=%h err=%b busy=%b rdy=%b%b we=%b, expected 1 0 %h %b 1 00 0",
                 tag, i, rv, ov, rd, re, busy, req0_ready, req1_ready, mem_we, exp_data, exp_err);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== ta) begin
      n_err++;
      $display("FAIL %s idle: busy=%b valid=%b%b we=%b addr=%h, expected busy=0 valid=00 we=0 addr=%h",
               tag, busy, rsp0_valid, rsp1_valid, mem_we, mem_addr, ta);
    end
    model_last = g;
    if (exp_we) ref_mem[ta[9:0]] = td;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_load = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_we = 1'b1; req1_we = 1'b1;
    req0_addr = 32'd3; req1_addr = 32'd4; req0_wdata = 32'h1; req1_wdata = 32'h2;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clk); #1 mem_load = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0 ||
        rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_rdata !== 32'd0 || rsp1_rdata !== 32'd0 ||
        rsp0_err !== 1'b0 || rsp1_err !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset: rdy=%b%b busy=%b we=%b valid=%b%b rdata=%h err=%b addr=%h, expected all zero",
               req0_ready, req1_ready, busy, mem_we, rsp0_valid, rsp1_valid, rsp0_rdata, rsp0_err, mem_addr);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic test_single_write;
    run_txn(1, 0, 1, 32'd5, 32'hDEAD_BEEF, 0, 32'd0, 32'd0, 0, "single_write");
  endtask

  task automatic test_read_back;
    run_txn(0, 1, 0, 32'd0, 32'd0, 0, 32'd5, 32'd0, 0, "read_back");
  endtask

  task automatic test_out_of_range;
    run_txn(1, 0, 1, 32'd1024, 32'h1234_5678, 0, 32'd0, 32'd0, 0, "oor_write");
    run_txn(1, 0, 0, 32'd1024, 32'd0, 0, 32'd0, 32'd0, 0, "oor_read");
    run_txn(0, 1, 0, 32'd0, 32'd0, 0, 32'd1023, 32'd0, 1, "last_word_read");
  endtask

  task automatic test_backpressure;
    run_txn(0, 1, 0, 32'd0, 32'd0, 0, 32'd5, 32'd0, 5, "backpressure");
  endtask

  task automatic test_drop_request;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'd9; req0_wdata = 32'hFFFF_0000;
    #2 req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL drop_request[%0d]: busy=%b rdy=%b%b we=%b, expected 0 00 0",
                 i, busy, req0_ready, req1_ready, mem_we);
      end
    end
  endtask

  task automatic test_back_to_back;
    int          port, phase;
    logic [31:0] exp_data;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'd1; req0_wdata = 32'd0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'd2; req1_wdata = 32'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    for (int k = 0; k < 12; k++) begin
      phase = k % 3;
      port  = ((k / 3) % 2 == 0) ? (model_last ? 0 : 1) : (model_last ? 1 : 0);
      exp_data = (port == 1) ? ref_mem[2] : ref_mem[1];
      #1;
      n_cmp++;
      if (phase == 0) begin
        if (req0_ready !== (port == 0) || req1_ready !== (port == 1) || busy !== 1'b0) begin
          n_err++;
          $display("FAIL b2b[%0d] grant: rdy=%b%b busy=%b, expected port %0d", k, req0_ready, req1_ready, busy, port);
        end
      end else if (phase == 1) begin
        if (busy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ((port == 1) ? 32'd2 : 32'd1)) begin
          n_err++;
          $display("FAIL b2b[%0d] access: busy=%b we=%b addr=%h, expected port %0d", k, busy, mem_we, mem_addr, port);
        end
      end else begin
        if (rsp0_valid !== (port == 0) || rsp1_valid !== (port == 1) ||
            ((port == 1) ? rsp1_rdata : rsp0_rdata) !== exp_data) begin
          n_err++;
          $display("FAIL b2b[%0d] resp: valid=%b%b rdata=%h/%h, expected port %0d rdata=%h",
                   k, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, port, exp_data);
        end
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_reset_midop;
    logic [31:0] wd;
    wd = ~ref_mem[7];
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'd7; req0_wdata = wd;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midop grant: ready0=%b, expected 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 32'd7) begin
      n_err++;
      $display("FAIL midop access: we=%b addr=%h, expected we=1 addr=7", mem_we, mem_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp0_rdata !== 32'd0 || req0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midop abort: we=%b busy=%b valid=%b rdata=%h, expected 0 0 0 0", mem_we, busy, rsp0_valid, rsp0_rdata);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (tb_mem[7] !== ref_mem[7]) begin
      n_err++;
      $display("FAIL midop memory: word7=%h, expected %h", tb_mem[7], ref_mem[7]);
    end
    @(negedge clk);
    rst_n = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    model_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL midop after[%0d]: valid=%b%b busy=%b, expected 00 0", i, rsp0_valid, rsp1_valid, busy);
      end
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [1:0]  pat;
    logic [31:0] a0, a1;
    for (int n = 0; n < 40; n++) begin
      pat = 2'($urandom_range(1, 3));
      a0 = ($urandom_range(0, 7) == 0) ? 32'd1024 + $urandom_range(0, 100000) : $urandom_range(0, 15);
      a1 = ($urandom_range(0, 7) == 0) ? 32'd1023 : $urandom_range(0, 15);
      run_txn(pat[0], pat[1], 1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom,
              $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    salt = $urandom;
    for (int i = 0; i < 1024; i++) ref_mem[i] = (i * 32'h9E37_79B9) ^ salt;
    test_reset();
    test_single_write();
    test_read_back();
    test_out_of_range();
    test_backpressure();
    test_drop_request();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
